// File: rtl/rlcn_pkg.sv
// Shared definitions for the rlcn loadable counter: limit-behaviour encodings
// and the elaboration-time legality check for the MODE parameter.
package rlcn_pkg;

  localparam int RLCN_WRAP   = 0;
  localparam int RLCN_RELOAD = 1;
  localparam int RLCN_SAT    = 2;

  function automatic bit rlcn_mode_ok(input int mode);
    return (mode == RLCN_WRAP) || (mode == RLCN_RELOAD) || (mode == RLCN_SAT);
  endfunction

endpackage

// File: rtl/rlcn_add.sv
// WIDTH-bit ripple adder with carry-out, shared by the add and count paths.
// Purely combinational; no backpressure.
module rlcn_add #(
  parameter int WIDTH = 22
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rlcn.sv
// Loadable up-counter with add, wrap/reload/saturate limit handling and carry chain.
// One-edge latency from strobes to q/ao/tc; strobes are never stalled.
module rlcn
  import rlcn_pkg::*;
#(
  parameter int     WIDTH = 22,
  parameter longint STEP  = 1,
  parameter int     MODE  = RLCN_WRAP
) (
  input  logic             c,
  input  logic             xr,
  input  logic             l,
  input  logic [WIDTH-1:0] dl,
  input  logic             r,
  input  logic [WIDTH-1:0] dr,
  input  logic             ci,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] xq,
  output logic             co,
  output logic             ao,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("rlcn: WIDTH %0d outside 2..32", WIDTH);
  end
  if (STEP < 1 || STEP > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
    $error("rlcn: STEP %0d outside 1..2^WIDTH-1", STEP);
  end
  if (!rlcn_mode_ok(MODE)) begin : g_bad_mode
    $error("rlcn: MODE %0d is not a known encoding", MODE);
  end

  localparam logic [WIDTH-1:0] STEP_W  = STEP[WIDTH-1:0];
  localparam logic             IS_WRAP = (MODE == RLCN_WRAP);
  localparam logic             IS_RELD = (MODE == RLCN_RELOAD);

  logic [WIDTH-1:0] q_r, base_r, q_nxt, base_nxt;
  logic [WIDTH-1:0] opnd, sum;
  logic             ao_r, tc_r, ao_nxt, tc_nxt;
  logic             cout, at_lim;

  // One adder serves both paths: r selects the add operand, otherwise STEP.
  assign opnd = r ? dr : STEP_W;

  rlcn_add #(.WIDTH(WIDTH)) u_add (
    .a  (q_r),
    .b  (opnd),
    .s  (sum),
    .co (cout)
  );

  assign at_lim = (q_r == lim);

  always_comb begin
    q_nxt    = q_r;
    base_nxt = base_r;
    ao_nxt   = ao_r;
    tc_nxt   = 1'b0;
    if (l) begin
      q_nxt    = dl;
      base_nxt = dl;
      ao_nxt   = 1'b0;
    end else if (r) begin
      q_nxt  = sum;
      ao_nxt = cout;
    end else if (ci) begin
      if (IS_WRAP) begin
        q_nxt  = sum;
        tc_nxt = cout;
      end else if (at_lim) begin
        q_nxt  = IS_RELD ? base_r : q_r;
        tc_nxt = 1'b1;
      end else begin
        q_nxt = sum;
      end
    end
  end

  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      q_r    <= '0;
      base_r <= '0;
      ao_r   <= 1'b0;
      tc_r   <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      base_r <= base_nxt;
      ao_r   <= ao_nxt;
      tc_r   <= tc_nxt;
    end
  end

  assign q  = q_r;
  assign xq = ~q_r;
  assign ao = ao_r;
  assign tc = tc_r;
  // Active-low chain carry; only wrap mode can ripple into a following stage.
  assign co = ~(ci & (&q_r) & IS_WRAP);

endmodule

// File: tb/tb_rlcn.sv
// Scoreboard bench for rlcn: three 8-bit instances (wrap, reload, saturate/STEP=2)
// share stimulus; directed vectors push expectations, a monitor pops and compares.
module tb_rlcn;

  logic       c, xr, l, r, ci;
  logic [7:0] dl, dr, lim;
  logic [7:0] qa [3];
  logic [7:0] xqa[3];
  logic       coa[3], aoa[3], tca[3];

  rlcn #(.WIDTH(8), .STEP(1), .MODE(0)) d0 (
    .c(c), .xr(xr), .l(l), .dl(dl), .r(r), .dr(dr), .ci(ci), .lim(lim),
    .q(qa[0]), .xq(xqa[0]), .co(coa[0]), .ao(aoa[0]), .tc(tca[0]));
  rlcn #(.WIDTH(8), .STEP(1), .MODE(1)) d1 (
    .c(c), .xr(xr), .l(l), .dl(dl), .r(r), .dr(dr), .ci(ci), .lim(lim),
    .q(qa[1]), .xq(xqa[1]), .co(coa[1]), .ao(aoa[1]), .tc(tca[1]));
  rlcn #(.WIDTH(8), .STEP(2), .MODE(2)) d2 (
    .c(c), .xr(xr), .l(l), .dl(dl), .r(r), .dr(dr), .ci(ci), .lim(lim),
    .q(qa[2]), .xq(xqa[2]), .co(coa[2]), .ao(aoa[2]), .tc(tca[2]));

  typedef struct {
    int       cyc;
    int       d;
    logic [7:0] q;
    logic     ao;
    logic     tc;
    logic     cco;
    logic     co;
    int       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  event chk_ev;
  int   cyc   = 0;
  int   tagn  = 0;
  int   total = 0;
  int   bad   = 0;
  bit   fin   = 0;

  initial c = 1'b0;
  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic push(input int ecyc, input int d, input logic [7:0] eq,
                      input logic eao, input logic etc, input logic cco, input logic eco);
    exp_t x;
    x.cyc = ecyc; x.d = d; x.q = eq; x.ao = eao; x.tc = etc;
    x.cco = cco; x.co = eco; x.tag = tagn;
    tagn++;
    sb.push_back(x);
  endtask

  // Inputs change 1ns after a rising edge; the expectation is for the next edge.
  task automatic drive(input logic il, input logic [7:0] idl, input logic ir,
                       input logic [7:0] idr, input logic ici, input logic [7:0] ilim,
                       input int d, input logic [7:0] eq, input logic eao,
                       input logic etc, input logic cco, input logic eco);
    @(posedge c);
    #1;
    l = il; dl = idl; r = ir; dr = idr; ci = ici; lim = ilim;
    push(cyc + 1, d, eq, eao, etc, cco, eco);
  endtask

  task automatic cmp(input string nm, input int tag, input logic [7:0] act,
                     input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step%0d got=%0h want=%0h", nm, tag, act, req);
    end
  endtask

  always begin
    @(negedge c or chk_ev);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      cmp("q",  e.tag, qa[e.d], e.q);
      cmp("xq", e.tag, xqa[e.d], ~e.q);
      cmp("ao", e.tag, 8'(aoa[e.d]), 8'(e.ao));
      cmp("tc", e.tag, 8'(tca[e.d]), 8'(e.tc));
      if (e.cco) cmp("co", e.tag, 8'(coa[e.d]), 8'(e.co));
    end
    if (fin) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL drain left=%0d want=0", sb.size());
      end
    end
  end

  initial begin
    xr = 1'b0; l = 1'b0; r = 1'b0; ci = 1'b1; dl = 8'h00; dr = 8'h00; lim = 8'h05;
    #12;
    for (int k = 0; k < 3; k++) push(cyc, k, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    -> chk_ev;
    #6;
    xr = 1'b1; ci = 1'b0;

    // wrap through all-ones, tc on the edge producing 0x00, co low at 0xFF
    drive(1, 8'hFE, 0, 8'h00, 0, 8'h05, 0, 8'hFE, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 8'hFF, 0, 0, 1, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 8'h00, 0, 1, 1, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 8'h01, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h05, 0, 8'h01, 0, 0, 0, 1);

    // add with carry, ao held through count and hold
    drive(1, 8'hF0, 0, 8'h00, 0, 8'h05, 0, 8'hF0, 0, 0, 0, 1);
    drive(0, 8'h00, 1, 8'h20, 0, 8'h05, 0, 8'h10, 1, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 8'h11, 1, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h05, 0, 8'h11, 1, 0, 0, 1);
    drive(0, 8'h00, 1, 8'h01, 0, 8'h05, 0, 8'h12, 0, 0, 0, 1);

    // reload at lim=5
    drive(1, 8'h03, 0, 8'h00, 0, 8'h05, 1, 8'h03, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h04, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h05, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h03, 0, 1, 1, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h04, 0, 0, 0, 1);

    // saturate at lim=6 with STEP=2
    drive(1, 8'h02, 0, 8'h00, 0, 8'h06, 2, 8'h02, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h06, 2, 8'h04, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h06, 2, 8'h06, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h06, 2, 8'h06, 0, 1, 1, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h06, 2, 8'h06, 0, 1, 0, 1);

    // load straight to lim in reload mode, then stepping past lim wraps silently
    drive(1, 8'h05, 0, 8'h00, 0, 8'h05, 1, 8'h05, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h05, 0, 1, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h05, 0, 1, 0, 1);
    drive(1, 8'hFE, 0, 8'h00, 0, 8'h05, 1, 8'hFE, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'hFF, 0, 0, 1, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h00, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h01, 0, 0, 0, 1);

    // all strobes on one edge: load wins and clears ao
    drive(1, 8'hF0, 0, 8'h00, 0, 8'h05, 0, 8'hF0, 0, 0, 0, 1);
    drive(0, 8'h00, 1, 8'h20, 0, 8'h05, 0, 8'h10, 1, 0, 0, 1);
    drive(1, 8'h40, 1, 8'hFF, 1, 8'h05, 0, 8'h40, 0, 0, 0, 1);

    // asynchronous reset mid-count with q=0x33, ao=1
    drive(1, 8'h43, 0, 8'h00, 0, 8'h05, 0, 8'h43, 0, 0, 0, 1);
    drive(0, 8'h00, 1, 8'hF0, 0, 8'h05, 0, 8'h33, 1, 0, 0, 1);
    @(posedge c);
    #1;
    l = 1'b0; r = 1'b0; ci = 1'b1;
    @(negedge c);
    #2;
    xr = 1'b0;
    #1;
    push(cyc, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    -> chk_ev;
    @(posedge c);
    #3;
    xr = 1'b1;
    push(cyc + 1, 0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 8'h02, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 8'h00, 0, 8'h05, 0, 8'h02, 0, 0, 0, 1);

    repeat (2) @(negedge c);
    #1;
    fin = 1'b1;
    -> chk_ev;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
